conv3x3_mac_relu: RTL

CONV3X3_MAC_RELU -- requirements
Module: conv3x3_mac_relu

---
 rtl/conv3x3_mac_relu.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/conv3x3_mac_relu.sv
// ---------------------------------------------------------------------------
// conv3x3_mac_relu
//
// Purpose: one output pixel of a 3x3 convolution per accepted window. The
// nine unsigned pixels are multiplied by nine programmable signed weights,
// summed with a programmable signed bias, then passed through ReLU, a right
// shift by SHIFT and saturation to 8 bits. Three registered stages advance
// together under a valid/ready handshake.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   valid_in, ready_out      upstream handshake (window accepted on both high)
//   data_in_0..data_in_8     unsigned window pixels, pixel k uses weight k
//   weight_we/addr/data      weight write port (addresses 9..15 ignored)
//   bias_we, bias_data       bias write port
//   valid_out, ready_in      downstream handshake
//   data_out                 unsigned ReLU-quantised result
// ---------------------------------------------------------------------------
module conv3x3_mac_relu #(
    parameter int SHIFT = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic [7:0]  data_in_0,
    input  logic [7:0]  data_in_1,
    input  logic [7:0]  data_in_2,
    input  logic [7:0]  data_in_3,
    input  logic [7:0]  data_in_4,
    input  logic [7:0]  data_in_5,
    input  logic [7:0]  data_in_6,
    input  logic [7:0]  data_in_7,
    input  logic [7:0]  data_in_8,
    input  logic        weight_we,
    input  logic [3:0]  weight_addr,
    input  logic [7:0]  weight_data,
    input  logic        bias_we,
    input  logic [15:0] bias_data,
    output logic        valid_out,
    input  logic        ready_in,
    output logic [7:0]  data_out
);

    logic               w_adv;
    logic [7:0]         w_pix [9];
    logic signed [16:0] w_prod [9];
    logic signed [20:0] w_prodSum;
    logic signed [21:0] w_s2Next;
    logic [21:0]        w_shifted;
    logic [7:0]         w_relu;

    logic signed [7:0]  r_weight [9];
    logic signed [15:0] r_bias;
    logic               r_s1Valid;
    logic               r_s2Valid;
    logic               r_s3Valid;
    logic signed [16:0] r_prod [9];
    logic signed [21:0] r_s2Sum;
    logic [7:0]         r_dataOut;

    assign w_pix[0] = data_in_0;
    assign w_pix[1] = data_in_1;
    assign w_pix[2] = data_in_2;
    assign w_pix[3] = data_in_3;
    assign w_pix[4] = data_in_4;
    assign w_pix[5] = data_in_5;
    assign w_pix[6] = data_in_6;
    assign w_pix[7] = data_in_7;
    assign w_pix[8] = data_in_8;

    // The whole pipe moves as one; it only freezes when a result is waiting
    // for a downstream that is not ready.
    assign w_adv     = !valid_out || ready_in;
    assign ready_out = w_adv;
    assign valid_out = r_s3Valid;
    assign data_out  = r_dataOut;

    // S1 products: pixel zero-extended, weight sign-extended, both to 17 bits.
    // The true product range (-32640..32385) fits 17-bit signed exactly.
    always_comb begin
        for (int k = 0; k < 9; k++) begin
            w_prod[k] = $signed({9'b0, w_pix[k]}) * $signed({{9{r_weight[k][7]}}, r_weight[k]});
        end
    end

    // S2 adder tree: nine 17-bit products need 21 bits; one more bit makes
    // room for the 16-bit bias so the result can never overflow.
    always_comb begin
        w_prodSum = '0;
        for (int k = 0; k < 9; k++) begin
            w_prodSum = w_prodSum + {{4{r_prod[k][16]}}, r_prod[k]};
        end
        w_s2Next = {w_prodSum[20], w_prodSum} + {{6{r_bias[15]}}, r_bias};
    end

    // S3 ReLU, truncating shift and saturation to the 8-bit output range.
    always_comb begin
        w_shifted = $unsigned(r_s2Sum) >> SHIFT;
        if (r_s2Sum[21]) begin
            w_relu = 8'd0;
        end else if (w_shifted > 22'd255) begin
            w_relu = 8'd255;
        end else begin
            w_relu = w_shifted[7:0];
        end
    end

    // Parameter registers are written independently of the pipeline state.
    // The pipeline samples the pre-edge values, so a write on the same edge
    // as an acceptance (weights) or S2 entry (bias) does not affect it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) begin
                r_weight[k] <= '0;
            end
            r_bias <= '0;
        end else begin
            if (weight_we && (weight_addr < 4'd9)) begin
                r_weight[weight_addr] <= weight_data;
            end
            if (bias_we) begin
                r_bias <= bias_data;
            end
        end
    end

    // Pipeline registers: valid flags and data shift together on w_adv.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1Valid <= 1'b0;
            r_s2Valid <= 1'b0;
            r_s3Valid <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                r_prod[k] <= '0;
            end
            r_s2Sum   <= '0;
            r_dataOut <= '0;
        end else if (w_adv) begin
            r_s1Valid <= valid_in;
            r_s2Valid <= r_s1Valid;
            r_s3Valid <= r_s2Valid;
            r_prod    <= w_prod;
            r_s2Sum   <= w_s2Next;
            r_dataOut <= w_relu;
        end
    end

endmodule
